ram_arbiter: RTL

- Shares the single-port data RAM between two requesters: the CPU MEM stage (port 0) and the UART program/data loader (port 1).
- Sits between the MEM-stage RAM control signals and the RAM instance.
- Grants at most one access per cycle and routes the 1-cycle-latency read data back to the owning requester.
- Produces a stall flag that the stage controller uses to hold the pipeline strobes.

---
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/ram_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side RAM access channel: one instance per port sharing the data RAM.
// The requester drives req/wren/address/write_data; the arbiter answers with gnt/rvalid/stall.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  wren;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  gnt;
    logic                  rvalid;
    logic                  stall;

    modport master (
        output req,
        output wren,
        output address,
        output write_data,
        input  gnt,
        input  rvalid,
        input  stall
    );

    modport slave (
        input  req,
        input  wren,
        input  address,
        input  write_data,
        output gnt,
        output rvalid,
        output stall
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single-port data RAM (port 0 = CPU MEM stage,
// port 1 = UART loader). One access per cycle, read data returns one cycle later.
module ram_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_arbiter_if.slave          p0,
    ram_arbiter_if.slave          p1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_data
);

    localparam bit FIXED = (FIXED_PRIORITY != 0);

    typedef enum logic {
        LAST_P0 = 1'b0,
        LAST_P1 = 1'b1
    } last_e;

    last_e                 last_q;
    last_e                 last_d;
    logic                  gnt0;
    logic                  gnt1;
    logic                  any_gnt;
    logic                  win_wren;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  pend_vld_d;
    logic                  pend_owner_d;
    logic                  pend_vld_p1;
    logic                  pend_owner_p1;
    logic [ADDR_WIDTH-1:0] held_addr_q;
    logic [DATA_WIDTH-1:0] held_wdata_q;

    // Arbitration: under conflict the port that did not win last time goes next,
    // unless the CPU is given absolute priority.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (p0.req && p1.req) begin
                if (FIXED || (last_q == LAST_P1)) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = p0.req;
                gnt1 = p1.req;
            end
        end
        any_gnt   = gnt0 | gnt1;
        win_wren  = gnt1 ? p1.wren       : p0.wren;
        win_addr  = gnt1 ? p1.address    : p0.address;
        win_wdata = gnt1 ? p1.write_data : p0.write_data;
    end

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = LAST_P0;
        end else if (gnt1) begin
            last_d = LAST_P1;
        end
        pend_vld_d   = any_gnt & ~win_wren;
        pend_owner_d = gnt1;
    end

    // Stage p0 -> p1: pointer, pending-read tag and the idle-bus hold values.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q        <= LAST_P1;
            pend_vld_p1   <= 1'b0;
            pend_owner_p1 <= 1'b0;
            held_addr_q   <= '0;
            held_wdata_q  <= '0;
        end else begin
            last_q        <= last_d;
            pend_vld_p1   <= pend_vld_d;
            pend_owner_p1 <= pend_owner_d;
            if (any_gnt) begin
                held_addr_q  <= win_addr;
                held_wdata_q <= win_wdata;
            end
        end
    end

    // Reset also masks the return path so an in-flight read is dropped at once.
    always_comb begin
        p0.gnt    = gnt0;
        p1.gnt    = gnt1;
        p0.stall  = p0.req & ~gnt0;
        p1.stall  = p1.req & ~gnt1;
        p0.rvalid = ~reset & pend_vld_p1 & ~pend_owner_p1;
        p1.rvalid = ~reset & pend_vld_p1 &  pend_owner_p1;
        rdata     = (pend_vld_p1 && !reset) ? ram_data : '0;
        ram_wren  = any_gnt & win_wren;
        if (reset) begin
            ram_address    = '0;
            ram_write_data = '0;
        end else if (any_gnt) begin
            ram_address    = win_addr;
            ram_write_data = win_wdata;
        end else begin
            ram_address    = held_addr_q;
            ram_write_data = held_wdata_q;
        end
    end

endmodule
